// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with ready/ack data-memory access, load extension and stall/fault control
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INST_WIDTH-1:0]          INST_EX,
  input  logic                           reg_write_EX,
  input  logic                           mem_write_EX,
  input  logic [1:0]                     result_sel_EX,
  input  logic [DATA_WIDTH-1:0]          alu_res_EX,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  input  logic [DATA_WIDTH-1:0]          write_data_EX,
  input  logic [DATA_WIDTH-1:0]          PC_plus_4_EX,
  input  logic [2:0]                     funct3_EX,
  output logic [INST_WIDTH-1:0]          INST_EX_MEM_o,
  output logic                           reg_write_EX_MEM_o,
  output logic [1:0]                     result_sel_EX_MEM_o,
  output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
  output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
  output logic [DATA_WIDTH-1:0]          PC_plus_4_EX_MEM_o,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DATA_WIDTH-1:0]          dmem_addr,
  output logic [3:0]                     dmem_be,
  output logic [DATA_WIDTH-1:0]          dmem_wdata,
  input  logic [DATA_WIDTH-1:0]          dmem_rdata,
  input  logic                           dmem_ack,
  output logic [DATA_WIDTH-1:0]          load_data_MEM,
  output logic                           reg_write_MEM,
  output logic                           valid_MEM,
  output logic                           stall_MEM,
  output logic                           misalign_fault_MEM,
  output logic                           timeout_fault_MEM
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic mem_write_q, live_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic [2:0] funct3_q;
  logic access, timeout, misal, capture_mem;
  logic [1:0] sh;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [3:0] be_raw;
  logic [DATA_WIDTH-1:0] wdata_raw, ext;

  function automatic logic is_mem(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3);
    return mw ? (f3 inside {3'b000, 3'b001, 3'b010})
              : (rw && rs == 2'b01 && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
  endfunction

  function automatic logic aligned(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? (a == 2'b00) : f3[0] ? !a[0] : 1'b1;
  endfunction

  always_comb begin
    access      = state == ACCESS;
    timeout     = access && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    stall_MEM   = access && !dmem_ack && !timeout;
    misal       = live_q && is_mem(reg_write_EX_MEM_o, mem_write_q, result_sel_EX_MEM_o, funct3_q)
                  && !aligned(funct3_q, alu_res_EX_MEM_o[1:0]);
    capture_mem = is_mem(reg_write_EX, mem_write_EX, result_sel_EX, funct3_EX) && aligned(funct3_EX, alu_res_EX[1:0]);
    state_nx    = (stall_MEM || capture_mem) ? ACCESS : IDLE;
    valid_MEM          = !stall_MEM && live_q;
    misalign_fault_MEM = misal;
    timeout_fault_MEM  = timeout;
    reg_write_MEM      = valid_MEM && reg_write_EX_MEM_o && !misal && !timeout;
    sh        = alu_res_EX_MEM_o[1:0];
    be_raw    = funct3_q[1] ? 4'b1111 : funct3_q[0] ? 4'b0011 << sh : 4'b0001 << sh;
    wdata_raw = funct3_q[1] ? write_data_q : funct3_q[0] ? {2{write_data_q[15:0]}} : {4{write_data_q[7:0]}};
    dmem_req   = access;
    dmem_we    = access && mem_write_q;
    dmem_addr  = access ? {alu_res_EX_MEM_o[DATA_WIDTH-1:2], 2'b00} : '0;
    dmem_be    = access ? be_raw : 4'b0000;
    dmem_wdata = (access && mem_write_q) ? wdata_raw : '0;
    lb  = dmem_rdata[{sh, 3'b000} +: 8];
    lh  = dmem_rdata[{sh[1], 4'b0000} +: 16];
    ext = funct3_q == 3'b000 ? {{24{lb[7]}}, lb} :
          funct3_q == 3'b001 ? {{16{lh[15]}}, lh} :
          funct3_q == 3'b010 ? dmem_rdata :
          funct3_q == 3'b100 ? {24'd0, lb} :
          funct3_q == 3'b101 ? {16'd0, lh} : '0;
    load_data_MEM = (access && dmem_ack && !mem_write_q) ? ext : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      live_q              <= 1'b0;
      INST_EX_MEM_o       <= INST_WIDTH'(32'h00000013);
      reg_write_EX_MEM_o  <= 1'b0;
      mem_write_q         <= 1'b0;
      result_sel_EX_MEM_o <= 2'b00;
      alu_res_EX_MEM_o    <= '0;
      rd_EX_MEM_o         <= '0;
      write_data_q        <= '0;
      PC_plus_4_EX_MEM_o  <= '0;
      funct3_q            <= 3'b000;
    end else begin
      state <= state_nx;
      cnt   <= stall_MEM ? cnt + CW'(1) : '0;
      if (!stall_MEM) begin
        live_q              <= 1'b1;
        INST_EX_MEM_o       <= INST_EX;
        reg_write_EX_MEM_o  <= reg_write_EX;
        mem_write_q         <= mem_write_EX;
        result_sel_EX_MEM_o <= result_sel_EX;
        alu_res_EX_MEM_o    <= alu_res_EX;
        rd_EX_MEM_o         <= rd_EX;
        write_data_q        <= write_data_EX;
        PC_plus_4_EX_MEM_o  <= PC_plus_4_EX;
        funct3_q            <= funct3_EX;
      end
    end
  end
endmodule

// File: doc/ex_mem_stage.md
# EX_MEM_stage

EX/MEM pipeline register plus data-memory access unit, directly downstream of the EX datapath. Captures the EX-stage results each cycle, drives a ready/ack data-memory bus for loads and stores (byte enables, store-data alignment, load sign/zero extension), and stalls the pipeline while an access is outstanding. It supplies `alu_res_EX_MEM_o` for EX forwarding and the MEM-stage results consumed by the MEM/WB register.

## Interface
- DATA_WIDTH, 32, data/address width (only 32 supported)
- INST_WIDTH, 32, instruction width
- REGISTER_ADDR_WIDTH, 5, register index width
- TIMEOUT_CYCLES, 16, max cycles an access waits for `dmem_ack` (≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- INST_EX, reg_write_EX, mem_write_EX, result_sel_EX[1:0], alu_res_EX[31:0], rd_EX[4:0], write_data_EX[31:0], PC_plus_4_EX[31:0], funct3_EX[2:0]  in  EX-stage results
- INST_EX_MEM_o, reg_write_EX_MEM_o, result_sel_EX_MEM_o, alu_res_EX_MEM_o, rd_EX_MEM_o, PC_plus_4_EX_MEM_o  out  registered copies (forwarding/hazard use)
- dmem_req  out  1  access request, level held until ack or timeout
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (`alu_res & ~3`)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  access complete
- load_data_MEM  out  32  extended load result, valid when `valid_MEM` and load
- reg_write_MEM  out  1  write-enable for MEM/WB (faults suppress)
- valid_MEM  out  1  instruction in EX/MEM retires this cycle
- stall_MEM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign_fault_MEM, timeout_fault_MEM  out  1  one-cycle fault pulses

## Operation
- result_sel encoding: 00 ALU, 01 memory, 10 PC+4. Load = `result_sel==01 && reg_write`; store = `mem_write`.
- EX/MEM register loads EX inputs on every edge where `stall_MEM==0`; holds otherwise.
- Alignment: word needs addr[1:0]==0; half needs addr[0]==0; byte any. Misaligned op: no request, `misalign_fault_MEM`=1 for its cycle, `reg_write_MEM`=0, `valid_MEM`=1.
- Stores: SB be=`0001<<a[1:0]`, wdata = byte replicated ×4; SH be=`0011<<a[1:0]`, half replicated ×2; SW be=1111. funct3 other than 000/001/010 → be=0000, no request, treated as non-mem op.
- Loads: be as above; lane selected by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; funct3 011/110/111 → result 0.
- FSM states IDLE, ACCESS. IDLE→ACCESS when an aligned mem op is captured. In ACCESS: `dmem_req`=1, cycle counter increments. ack → op retires; next state ACCESS if the newly captured op is an aligned mem op, else IDLE; counter clears. Counter reaches TIMEOUT_CYCLES-1 without ack → `timeout_fault_MEM`=1, `reg_write_MEM`=0, op retires, same next-state rule.
- `stall_MEM` = ACCESS && !dmem_ack && !timeout. `valid_MEM` = !stall_MEM && EX/MEM not a reset bubble.
- `dmem_ack` while IDLE is ignored.

## Timing
- Reset: all EX/MEM registers 0 except INST = 32'h00000013; state IDLE; counter 0; all outputs 0.
- Request asserted the cycle after capture; bus signals stable until ack/timeout.
- Zero-wait memory (ack in first ACCESS cycle): no stall, throughput 1/cycle, load data available in that same cycle.
- N-cycle wait: stall_MEM high N cycles; back-to-back mem ops each pay their own latency.
- Ack on the timeout cycle: ack wins, no fault.
- rst during ACCESS: request drops after the reset edge; no fault pulse.
- `alu_res_EX_MEM_o` is the raw registered ALU result (unmasked address).

## Test plan
- Zero-wait LW addr 0x100, rdata 0xDEADBEEF, ack immediate → req 1 cycle, stall_MEM never high, load_data_MEM 0xDEADBEEF, reg_write_MEM 1.
- LB addr 0x103, rdata 0x80FF_0000 → be 1000, load_data_MEM 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SH addr 0x102 data 0x1234ABCD → be 1100, wdata 0xABCDABCD, dmem_we 1, addr 0x100.
- Ack after 3 wait cycles → stall_MEM high exactly 3 cycles, EX/MEM and bus signals constant, retire on 4th cycle.
- No ack, TIMEOUT_CYCLES=16 → timeout_fault_MEM pulse on 16th ACCESS cycle, reg_write_MEM 0, stall released; ack on that cycle instead → no fault.
- LW addr 0x102 → no dmem_req, misalign_fault_MEM 1, reg_write_MEM 0; rst asserted mid-wait → all outputs 0, INST_EX_MEM_o 0x13 after edge.
